// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared FSM state type and 50 MHz default timings for touch pad conditioning
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        LONG_HELD,
        RELEASE_DB
    } touch_state_t;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_LONG_CYC     = 50_000_000;
    localparam int DEF_REPEAT_CYC   = 10_000_000;

endpackage

// File: rtl/touch_key_conditioner_if.sv
// rtl/touch_key_conditioner_if.sv - raw pad input and conditioned key event bundle
interface touch_key_conditioner_if;

    logic touch_key;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;

    modport master (
        input  touch_key,
        output key_level,
        output press_pulse,
        output release_pulse,
        output short_pulse,
        output long_pulse,
        output repeat_pulse
    );

    modport slave (
        output touch_key,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse
    );

endinterface

// File: rtl/touch_sync.sv
// rtl/touch_sync.sv - two-flop synchroniser for asynchronous pad inputs, reset to a chosen level
module touch_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic raw,
    output logic synced
);

    logic meta;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta   <= RST_VAL;
            synced <= RST_VAL;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/touch_key_conditioner.sv
// rtl/touch_key_conditioner.sv - touch pad debounce and short/long classifier; TOUCH_REPEAT_EN adds auto-repeat
module touch_key_conditioner
    import touch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int ACTIVE_HIGH  = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    touch_key_conditioner_if.master   key_if
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int LONG_W = $clog2(LONG_CYC + 1);
    localparam logic SYNC_RST = (ACTIVE_HIGH == 0);

    if (DEBOUNCE_CYC < 2 || LONG_CYC <= DEBOUNCE_CYC || REPEAT_CYC < 1) begin : g_param_check
        $error("touch_key_conditioner: illegal cycle parameters");
    end

    logic synced;
    logic s_key;

    touch_sync #(.RST_VAL(SYNC_RST)) u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .raw       (key_if.touch_key),
        .synced    (synced)
    );

    assign s_key = (ACTIVE_HIGH != 0) ? synced : ~synced;

    touch_state_t        state;
    logic                from_long;
    logic [DB_W-1:0]     db_cnt;
    logic [LONG_W-1:0]   hold_cnt;
    logic [DB_W-1:0]     db_next;
    logic [LONG_W-1:0]   hold_next;
    logic                level_r;
    logic                press_r;
    logic                release_r;
    logic                short_r;
    logic                long_r;

    assign db_next   = db_cnt + DB_W'(1);
    assign hold_next = hold_cnt + LONG_W'(1);

`ifdef TOUCH_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC + 1);
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic             repeat_r;

    assign rep_next            = rep_cnt + REP_W'(1);
    assign key_if.repeat_pulse = repeat_r;
`else
    assign key_if.repeat_pulse = 1'b0;
`endif

    // The IDLE->PRESS_DB and HELD->RELEASE_DB edges already count as the first stable
    // cycle, so the accept edge lands exactly DEBOUNCE_CYC samples after the change.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            from_long <= 1'b0;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
`ifdef TOUCH_REPEAT_EN
            rep_cnt   <= '0;
            repeat_r  <= 1'b0;
`endif
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
`ifdef TOUCH_REPEAT_EN
            repeat_r  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (s_key) begin
                        state  <= PRESS_DB;
                        db_cnt <= DB_W'(1);
                    end
                end
                PRESS_DB: begin
                    if (!s_key) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_next == DB_W'(DEBOUNCE_CYC)) begin
                        state    <= HELD;
                        level_r  <= 1'b1;
                        press_r  <= 1'b1;
                        hold_cnt <= '0;
                        db_cnt   <= '0;
                    end else begin
                        db_cnt <= db_next;
                    end
                end
                HELD: begin
                    hold_cnt <= hold_next;
                    if (hold_next == LONG_W'(LONG_CYC)) begin
                        state  <= LONG_HELD;
                        long_r <= 1'b1;
`ifdef TOUCH_REPEAT_EN
                        rep_cnt <= '0;
`endif
                    end else if (!s_key) begin
                        state     <= RELEASE_DB;
                        from_long <= 1'b0;
                        db_cnt    <= DB_W'(1);
                    end
                end
                LONG_HELD: begin
`ifdef TOUCH_REPEAT_EN
                    if (rep_next == REP_W'(REPEAT_CYC)) begin
                        repeat_r <= 1'b1;
                        rep_cnt  <= '0;
                    end else begin
                        rep_cnt <= rep_next;
                    end
`endif
                    if (!s_key) begin
                        state     <= RELEASE_DB;
                        from_long <= 1'b1;
                        db_cnt    <= DB_W'(1);
                    end
                end
                RELEASE_DB: begin
                    if (s_key) begin
                        state  <= from_long ? LONG_HELD : HELD;
                        db_cnt <= '0;
                    end else if (db_next == DB_W'(DEBOUNCE_CYC)) begin
                        state     <= IDLE;
                        level_r   <= 1'b0;
                        release_r <= 1'b1;
                        short_r   <= ~from_long;
                        from_long <= 1'b0;
                        db_cnt    <= '0;
                    end else begin
                        db_cnt <= db_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_if.key_level     = level_r;
    assign key_if.press_pulse   = press_r;
    assign key_if.release_pulse = release_r;
    assign key_if.short_pulse   = short_r;
    assign key_if.long_pulse    = long_r;

endmodule

// File: tb/tb_touch_key_conditioner.sv
// tb/tb_touch_key_conditioner.sv - scoreboard bench for touch_key_conditioner (optionally with TOUCH_REPEAT_EN)
module tb_touch_key_conditioner;
    import touch_pkg::*;

    // Output vector layout: {key_level, press, release, short, long, repeat}
    localparam logic [5:0] EV_PRESS   = 6'b110000;
    localparam logic [5:0] EV_REL_SH  = 6'b001100;
    localparam logic [5:0] EV_REL     = 6'b001000;
    localparam logic [5:0] EV_LONG    = 6'b100010;
    localparam logic [5:0] EV_REPEAT  = 6'b100001;

    typedef struct {
        int         cyc;
        logic [5:0] v;
        string      nm;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    logic prev_level = 1'b0;
    exp_t exp_q[$];

    touch_key_conditioner_if key_if ();

    touch_key_conditioner #(
        .DEBOUNCE_CYC (8),
        .LONG_CYC     (40),
        .REPEAT_CYC   (10),
        .ACTIVE_HIGH  (1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_if    (key_if)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [5:0] outs();
        return {key_if.key_level, key_if.press_pulse, key_if.release_pulse,
                key_if.short_pulse, key_if.long_pulse, key_if.repeat_pulse};
    endfunction

    task automatic push(input int c, input logic [5:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    task automatic check_vec(input string nm, input logic [5:0] got, input logic [5:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge sys_clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain pending=%0d next=%s want_cyc=%0d now=%0d",
                     nm, exp_q.size(), exp_q[0].nm, exp_q[0].cyc, cyc);
        end
    endtask

    // Monitor: any pulse or level edge must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        logic [5:0] o;
        exp_t e;
        if (!sys_rst_n) begin
            prev_level = 1'b0;
        end else begin
            o = outs();
            if (o[4:0] != 5'b0 || o[5] != prev_level) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d got=%b", cyc, o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.v !== o) begin
                        n_fail++;
                        $display("FAIL %s got=%b at cyc %0d want=%b at cyc %0d",
                                 e.nm, o, cyc, e.v, e.cyc);
                    end
                end
            end
            prev_level = o[5];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        key_if.touch_key = 1'b0;

        wait_neg(3);
        check_vec("reset_outputs", outs(), 6'b0);
        n_checks++;
        if (dut.state != IDLE) begin
            n_fail++;
            $display("FAIL reset_state got=%0d want=%0d", int'(dut.state), int'(IDLE));
        end
        #1 sys_rst_n = 1'b1;
        wait_neg(5);

        // Clean short press
        @(negedge sys_clk);
        key_if.touch_key = 1'b1;
        b = cyc;
        push(b + 10, EV_PRESS, "short_press");
        wait_neg(20);
        key_if.touch_key = 1'b0;
        push(b + 30, EV_REL_SH, "short_release");
        drain("short");
        wait_neg(5);

        // 5-cycle glitch
        @(negedge sys_clk);
        key_if.touch_key = 1'b1;
        wait_neg(5);
        key_if.touch_key = 1'b0;
        wait_neg(30);
        n_checks++;
        if (dut.state != IDLE) begin
            n_fail++;
            $display("FAIL glitch_state got=%0d want=%0d", int'(dut.state), int'(IDLE));
        end

        // Bouncy press: high 3, low 2, then stable
        @(negedge sys_clk);
        key_if.touch_key = 1'b1;
        b = cyc;
        wait_neg(3);
        key_if.touch_key = 1'b0;
        wait_neg(2);
        key_if.touch_key = 1'b1;
        push(b + 15, EV_PRESS, "bounce_press");
        wait_neg(25);
        key_if.touch_key = 1'b0;
        push(b + 40, EV_REL_SH, "bounce_release");
        drain("bounce");
        wait_neg(5);

        // 100-cycle hold
        @(negedge sys_clk);
        key_if.touch_key = 1'b1;
        b = cyc;
        push(b + 10, EV_PRESS, "long_press");
        push(b + 50, EV_LONG, "long_event");
`ifdef TOUCH_REPEAT_EN
        for (int k = 1; k <= 5; k++) push(b + 50 + 10 * k, EV_REPEAT, "long_repeat");
`endif
        wait_neg(100);
        key_if.touch_key = 1'b0;
        push(b + 110, EV_REL, "long_release");
        drain("long");
        wait_neg(5);

        // 4-cycle dip while HELD delays the long event by 4
        @(negedge sys_clk);
        key_if.touch_key = 1'b1;
        b = cyc;
        push(b + 10, EV_PRESS, "dip_press");
        wait_neg(40);
        key_if.touch_key = 1'b0;
        wait_neg(4);
        key_if.touch_key = 1'b1;
        push(b + 54, EV_LONG, "dip_long");
`ifdef TOUCH_REPEAT_EN
        for (int k = 1; k <= 3; k++) push(b + 54 + 10 * k, EV_REPEAT, "dip_repeat");
`endif
        wait_neg(46);
        key_if.touch_key = 1'b0;
        push(b + 100, EV_REL, "dip_release");
        drain("dip");
        wait_neg(5);

        // Reset while in LONG_HELD, pad stays touched
        @(negedge sys_clk);
        key_if.touch_key = 1'b1;
        b = cyc;
        push(b + 10, EV_PRESS, "rst_press");
        push(b + 50, EV_LONG, "rst_long");
        wait_neg(55);
        check_vec("pre_reset_level", outs(), 6'b100000);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_vec("reset_async_clear", outs(), 6'b0);
        wait_neg(2);
        #1 sys_rst_n = 1'b1;
        b = cyc;
        push(b + 10, EV_PRESS, "after_reset_press");
        wait_neg(20);
        key_if.touch_key = 1'b0;
        push(b + 30, EV_REL_SH, "after_reset_release");
        drain("after_reset");

        wait_neg(20);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue_empty got=%0d want=0", exp_q.size());
        end
        check_vec("final_idle_outputs", outs(), 6'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
